// File: rtl/bn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bn_pkg
// Purpose  : Shared FSM encoding, default sizes and signed saturation helper.
// Revision : 1.0
// ============================================================================
package bn_pkg;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_LANES     = 16;
  localparam int DEF_SLICES    = 4;
  localparam int DEF_PAR_DEPTH = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COMP = 2'd1,
    DONE = 2'd2
  } state_t;

  // Clamp a sign-extended value into the signed range of a w-bit field (w <= 62).
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                    input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/para_add_sat.sv
`default_nettype none
// ============================================================================
// Module   : para_add_sat
// Purpose  : Lane-parallel signed adder, saturating or wrapping per SAT_EN.
// Revision : 1.0
// ============================================================================
module para_add_sat
  import bn_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LANES  = DEF_LANES,
  parameter int SAT_EN = 1
) (
  input  logic [LANES*DATA_W-1:0] i_a,
  input  logic [LANES*DATA_W-1:0] i_b,
  output logic [LANES*DATA_W-1:0] o_sum
);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    if (SAT_EN != 0) begin : g_sat
      logic signed [DATA_W:0] w_sum;
      // One guard bit holds the exact sum of two DATA_W signed operands.
      assign w_sum = (DATA_W+1)'($signed(i_a[i*DATA_W +: DATA_W]))
                   + (DATA_W+1)'($signed(i_b[i*DATA_W +: DATA_W]));
      assign o_sum[i*DATA_W +: DATA_W] = DATA_W'(sat_signed(64'(w_sum), DATA_W));
    end else begin : g_wrap
      assign o_sum[i*DATA_W +: DATA_W] = i_a[i*DATA_W +: DATA_W] + i_b[i*DATA_W +: DATA_W];
    end
  end

endmodule
`default_nettype wire

// File: rtl/bn_add_gen.sv
`default_nettype none
// ============================================================================
// Module   : bn_add_gen
// Purpose  : Slice-serial BN-ADD: adds a parameter-table row to each slice of a word.
// Revision : 1.0
// ============================================================================
module bn_add_gen
  import bn_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int LANES     = DEF_LANES,
  parameter int SLICES    = DEF_SLICES,
  parameter int PAR_DEPTH = DEF_PAR_DEPTH,
  parameter int SAT_EN    = 1,
  localparam int SW       = LANES * DATA_W,
  localparam int W        = SW * SLICES,
  localparam int AW       = (PAR_DEPTH > 1) ? $clog2(PAR_DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  acc_res_w,
  input  logic          acc_res_v_w,
  output logic          acc_res_rdy_w,
  input  logic [AW-1:0] par_base,
  input  logic          par_wr_en,
  input  logic [AW-1:0] par_waddr,
  input  logic [SW-1:0] par_wdata,
  output logic [W-1:0]  bn_add_res_w,
  output logic          bn_add_res_v_w,
  input  logic          bn_add_res_rdy_w
);

  localparam int CW = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam int RW = AW + CW + 1;

  state_t                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [AW-1:0]            base_q, base_d;
  logic [SLICES-1:0][SW-1:0] word_q, word_d;
  logic [SLICES-1:0][SW-1:0] res_q, res_d;
  logic                     vld_q, vld_d;
  logic [SW-1:0]            tbl_q [PAR_DEPTH];

  logic                     w_accept;
  logic [RW-1:0]            w_row_sum;
  logic [AW-1:0]            w_row;
  logic [SW-1:0]            w_par;
  logic [SW-1:0]            w_sum;

  always_comb begin
    acc_res_rdy_w = 1'b0;
    unique case (state_q)
      IDLE:    acc_res_rdy_w = 1'b1;
      DONE:    acc_res_rdy_w = bn_add_res_rdy_w;
      default: acc_res_rdy_w = 1'b0;
    endcase
  end

  assign w_accept = acc_res_v_w & acc_res_rdy_w;

  // Row index wraps modulo the table depth, also for non-power-of-two depths.
  assign w_row_sum = RW'(base_q) + RW'(cnt_q);
  assign w_row     = AW'(w_row_sum % RW'(PAR_DEPTH));
  assign w_par     = tbl_q[w_row];

  para_add_sat #(
    .DATA_W (DATA_W),
    .LANES  (LANES),
    .SAT_EN (SAT_EN)
  ) u_add (
    .i_a   (word_q[cnt_q]),
    .i_b   (w_par),
    .o_sum (w_sum)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    word_d  = word_q;
    res_d   = res_q;
    vld_d   = vld_q;
    unique case (state_q)
      IDLE: begin
        if (w_accept) begin
          state_d = COMP;
          cnt_d   = '0;
          word_d  = acc_res_w;
          base_d  = par_base;
        end
      end
      COMP: begin
        res_d[cnt_q] = w_sum;
        if (cnt_q == CW'(SLICES - 1)) begin
          state_d = DONE;
          cnt_d   = '0;
          vld_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (bn_add_res_rdy_w) begin
          vld_d = 1'b0;
          if (w_accept) begin
            state_d = COMP;
            cnt_d   = '0;
            word_d  = acc_res_w;
            base_d  = par_base;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
      word_q  <= '0;
      res_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      word_q  <= word_d;
      res_q   <= res_d;
      vld_q   <= vld_d;
    end
  end

  // Table survives reset so parameters loaded once stay valid across aborts.
  always_ff @(posedge clk) begin
    if (par_wr_en) begin
      tbl_q[par_waddr] <= par_wdata;
    end
  end

  assign bn_add_res_w   = res_q;
  assign bn_add_res_v_w = vld_q;

endmodule
`default_nettype wire

// File: tb/tb_bn_add_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_bn_add_gen
// Purpose  : Self-checking bench for bn_add_gen (saturating and wrapping builds).
// Revision : 1.0
// ============================================================================
module tb_bn_add_gen;

  localparam int DW = 16;
  localparam int L  = 16;
  localparam int S  = 4;
  localparam int PD = 64;
  localparam int AW = 6;
  localparam int SW = DW * L;
  localparam int W  = SW * S;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  acc_res_w = '0;
  logic          acc_res_v_w = 1'b0;
  logic [AW-1:0] par_base = '0;
  logic          par_wr_en = 1'b0;
  logic [AW-1:0] par_waddr = '0;
  logic [SW-1:0] par_wdata = '0;
  logic          res_rdy = 1'b0;
  logic          rdy_s, rdy_w, vld_s, vld_w;
  logic [W-1:0]  res_s, res_w;

  int checks = 0;
  int errors = 0;
  logic [SW-1:0] mtbl [PD];

  always #5 clk = ~clk;

  bn_add_gen #(.SAT_EN(1)) dut_sat (
    .clk(clk), .rst(rst), .acc_res_w(acc_res_w), .acc_res_v_w(acc_res_v_w),
    .acc_res_rdy_w(rdy_s), .par_base(par_base), .par_wr_en(par_wr_en),
    .par_waddr(par_waddr), .par_wdata(par_wdata), .bn_add_res_w(res_s),
    .bn_add_res_v_w(vld_s), .bn_add_res_rdy_w(res_rdy)
  );

  bn_add_gen #(.SAT_EN(0)) dut_wrap (
    .clk(clk), .rst(rst), .acc_res_w(acc_res_w), .acc_res_v_w(acc_res_v_w),
    .acc_res_rdy_w(rdy_w), .par_base(par_base), .par_wr_en(par_wr_en),
    .par_waddr(par_waddr), .par_wdata(par_wdata), .bn_add_res_w(res_w),
    .bn_add_res_v_w(vld_w), .bn_add_res_rdy_w(res_rdy)
  );

  // Reference: every lane is an independent signed add, clamped or wrapped.
  function automatic logic [W-1:0] model(input logic [W-1:0] word, input int base, input bit sat);
    logic [W-1:0]  r;
    logic [SW-1:0] row;
    int a, b, s;
    r = '0;
    for (int k = 0; k < S; k++) begin
      row = mtbl[(base + k) % PD];
      for (int i = 0; i < L; i++) begin
        a = $signed(word[k*SW + i*DW +: DW]);
        b = $signed(row[i*DW +: DW]);
        s = a + b;
        if (sat) begin
          if (s > 32767) s = 32767;
          else if (s < -32768) s = -32768;
        end
        r[k*SW + i*DW +: DW] = s[DW-1:0];
      end
    end
    return r;
  endfunction

  function automatic int first_diff(input logic [W-1:0] a, input logic [W-1:0] b);
    for (int i = 0; i < W/DW; i++) if (a[i*DW +: DW] !== b[i*DW +: DW]) return i;
    return 0;
  endfunction

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] v;
    for (int j = 0; j < W/32; j++) v[j*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [SW-1:0] rand_row();
    logic [SW-1:0] v;
    for (int j = 0; j < SW/32; j++) v[j*32 +: 32] = $urandom;
    return v;
  endfunction

  // All tasks start and end 1 time unit after a rising edge.
  task automatic write_row(input int r, input logic [SW-1:0] d);
    par_wr_en = 1'b1; par_waddr = AW'(r); par_wdata = d;
    @(posedge clk); #1;
    par_wr_en = 1'b0;
    mtbl[r] = d;
  endtask

  task automatic accept_word(input logic [W-1:0] word, input int base);
    int n;
    acc_res_w = word; par_base = AW'(base); acc_res_v_w = 1'b1; n = 0;
    while (rdy_s !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    checks++;
    if (rdy_s !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout ready got %b exp 1", rdy_s);
    end
    @(posedge clk); #1;
    acc_res_v_w = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (vld_s !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
  endtask

  task automatic consume();
    res_rdy = 1'b1;
    @(posedge clk); #1;
    res_rdy = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (vld_s !== 1'b0 || vld_w !== 1'b0 || rdy_s !== 1'b1 || res_s !== '0 || res_w !== '0) begin
      errors++;
      $display("FAIL reset_state got vld=%b/%b rdy=%b res_zero=%b exp vld=0/0 rdy=1 res_zero=1",
               vld_s, vld_w, rdy_s, (res_s == '0 && res_w == '0));
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [W-1:0] word, exp;
    int n, ln;
    for (int r = 0; r < PD; r++) write_row(r, {L{DW'(r)}});
    word = {(S*L){16'h0001}};
    for (int k = 0; k < S; k++) exp[k*SW +: SW] = {L{DW'(k + 1)}};
    accept_word(word, 0);
    wait_valid(n);
    checks++;
    if (n !== S) begin errors++; $display("FAIL basic_latency got %0d edges exp %0d", n, S); end
    checks++;
    if (res_s !== exp) begin
      errors++; ln = first_diff(res_s, exp);
      $display("FAIL basic_res_sat lane %0d got %h exp %h", ln, res_s[ln*DW +: DW], exp[ln*DW +: DW]);
    end
    checks++;
    if (res_w !== exp) begin
      errors++; ln = first_diff(res_w, exp);
      $display("FAIL basic_res_wrap lane %0d got %h exp %h", ln, res_w[ln*DW +: DW], exp[ln*DW +: DW]);
    end
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (vld_s !== 1'b1 || res_s !== exp) begin
      errors++; $display("FAIL basic_hold got vld=%b stable=%b exp vld=1 stable=1", vld_s, res_s == exp);
    end
    consume();
    checks++;
    if (vld_s !== 1'b0 || rdy_s !== 1'b1) begin
      errors++; $display("FAIL basic_release got vld=%b rdy=%b exp vld=0 rdy=1", vld_s, rdy_s);
    end
  endtask

  task automatic test_sat();
    logic [SW-1:0] row;
    logic [W-1:0]  word, exp_s, exp_w;
    int n, ln;
    row = rand_row();
    row[15:0] = 16'h0020; row[31:16] = 16'hFFF0;
    write_row(5, row);
    for (int r = 6; r < 9; r++) write_row(r, rand_row());
    word = rand_word();
    word[15:0] = 16'h7FF0; word[31:16] = 16'h8005;
    exp_s = model(word, 5, 1'b1);
    exp_w = model(word, 5, 1'b0);
    accept_word(word, 5);
    wait_valid(n);
    checks++;
    if (res_s[15:0] !== 16'h7FFF || res_s[31:16] !== 16'h8000) begin
      errors++; $display("FAIL sat_bounds got %h %h exp 7fff 8000", res_s[15:0], res_s[31:16]);
    end
    checks++;
    if (res_w[15:0] !== 16'h8010 || res_w[31:16] !== 16'h7FF5) begin
      errors++; $display("FAIL wrap_bounds got %h %h exp 8010 7ff5", res_w[15:0], res_w[31:16]);
    end
    checks++;
    if (res_s !== exp_s) begin
      errors++; ln = first_diff(res_s, exp_s);
      $display("FAIL sat_word lane %0d got %h exp %h", ln, res_s[ln*DW +: DW], exp_s[ln*DW +: DW]);
    end
    checks++;
    if (res_w !== exp_w) begin
      errors++; ln = first_diff(res_w, exp_w);
      $display("FAIL wrap_word lane %0d got %h exp %h", ln, res_w[ln*DW +: DW], exp_w[ln*DW +: DW]);
    end
    consume();
  endtask

  task automatic test_wrap_rows();
    logic [W-1:0] exp, word;
    int n, ln;
    write_row(62, rand_row()); write_row(63, rand_row());
    write_row(0, rand_row());  write_row(1, rand_row());
    exp = {mtbl[1], mtbl[0], mtbl[63], mtbl[62]};
    accept_word('0, 62);
    wait_valid(n);
    checks++;
    if (res_w !== exp) begin
      errors++; ln = first_diff(res_w, exp);
      $display("FAIL base_wrap_rows lane %0d got %h exp %h", ln, res_w[ln*DW +: DW], exp[ln*DW +: DW]);
    end
    consume();
    word = rand_word();
    exp = model(word, 62, 1'b1);
    accept_word(word, 62);
    wait_valid(n);
    checks++;
    if (res_s !== exp) begin
      errors++; ln = first_diff(res_s, exp);
      $display("FAIL base_wrap_rand lane %0d got %h exp %h", ln, res_s[ln*DW +: DW], exp[ln*DW +: DW]);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] w1, w2, e1, e2;
    int b2, n, ln, bad;
    w1 = rand_word(); w2 = rand_word(); b2 = $urandom_range(0, PD - 1);
    e1 = model(w1, 17, 1'b1);
    e2 = model(w2, b2, 1'b1);
    accept_word(w1, 17);
    wait_valid(n);
    acc_res_w = w2; par_base = AW'(b2); acc_res_v_w = 1'b1;
    bad = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (vld_s !== 1'b1 || res_s !== e1 || rdy_s !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL stall_hold got %0d bad cycles exp 0 (vld=%b rdy=%b)", bad, vld_s, rdy_s);
    end
    res_rdy = 1'b1;
    @(posedge clk); #1;
    res_rdy = 1'b0; acc_res_v_w = 1'b0;
    checks++;
    if (vld_s !== 1'b0 || rdy_s !== 1'b0) begin
      errors++; $display("FAIL b2b_accept got vld=%b rdy=%b exp vld=0 rdy=0", vld_s, rdy_s);
    end
    wait_valid(n);
    checks++;
    if (n !== S) begin errors++; $display("FAIL b2b_latency got %0d edges exp %0d", n, S); end
    checks++;
    if (res_s !== e2) begin
      errors++; ln = first_diff(res_s, e2);
      $display("FAIL b2b_res lane %0d got %h exp %h", ln, res_s[ln*DW +: DW], e2[ln*DW +: DW]);
    end
    consume();
  endtask

  task automatic test_table_write();
    logic [SW-1:0] old1, new1;
    logic [W-1:0]  word, e1, e2;
    int n, ln;
    old1 = rand_row(); new1 = rand_row();
    write_row(1, old1);
    word = rand_word();
    e1 = model(word, 0, 1'b1);
    accept_word(word, 0);
    @(posedge clk); #1;
    par_wr_en = 1'b1; par_waddr = AW'(1); par_wdata = new1;
    @(posedge clk); #1;
    par_wr_en = 1'b0;
    mtbl[1] = new1;
    e2 = model(word, 0, 1'b1);
    wait_valid(n);
    checks++;
    if (n !== S - 2) begin errors++; $display("FAIL tblwr_latency got %0d edges exp %0d", n, S - 2); end
    checks++;
    if (res_s !== e1) begin
      errors++; ln = first_diff(res_s, e1);
      $display("FAIL tblwr_old lane %0d got %h exp %h", ln, res_s[ln*DW +: DW], e1[ln*DW +: DW]);
    end
    consume();
    accept_word(word, 0);
    wait_valid(n);
    checks++;
    if (res_s !== e2) begin
      errors++; ln = first_diff(res_s, e2);
      $display("FAIL tblwr_new lane %0d got %h exp %h", ln, res_s[ln*DW +: DW], e2[ln*DW +: DW]);
    end
    consume();
  endtask

  task automatic test_reset_mid();
    int bad;
    accept_word({(S*L){16'h1234}}, 3);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if (res_s !== '0 || vld_s !== 1'b0 || rdy_s !== 1'b1) begin
      errors++; $display("FAIL midreset_clear got res_zero=%b vld=%b rdy=%b exp 1 0 1",
                         res_s == '0, vld_s, rdy_s);
    end
    @(posedge clk); #1;
    rst = 1'b0; res_rdy = 1'b1;
    bad = 0;
    repeat (10) begin @(posedge clk); #1; if (vld_s !== 1'b0 || vld_w !== 1'b0) bad++; end
    res_rdy = 1'b0;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL midreset_novalid got %0d valid cycles exp 0", bad); end
  endtask

  task automatic test_random();
    logic [W-1:0] word, es, ew;
    int base, n, ln, bad;
    for (int it = 0; it < 15; it++) begin
      if ($urandom_range(0, 2) == 0) write_row($urandom_range(0, PD - 1), rand_row());
      word = rand_word();
      base = $urandom_range(0, PD - 1);
      es = model(word, base, 1'b1);
      ew = model(word, base, 1'b0);
      accept_word(word, base);
      wait_valid(n);
      checks++;
      if (n !== S) begin errors++; $display("FAIL rand_latency it %0d got %0d exp %0d", it, n, S); end
      checks++;
      if (res_s !== es) begin
        errors++; ln = first_diff(res_s, es);
        $display("FAIL rand_sat it %0d lane %0d got %h exp %h", it, ln, res_s[ln*DW +: DW], es[ln*DW +: DW]);
      end
      checks++;
      if (res_w !== ew) begin
        errors++; ln = first_diff(res_w, ew);
        $display("FAIL rand_wrap it %0d lane %0d got %h exp %h", it, ln, res_w[ln*DW +: DW], ew[ln*DW +: DW]);
      end
      bad = 0;
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; if (res_s !== es || vld_s !== 1'b1) bad++; end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL rand_stall it %0d got %0d bad cycles exp 0", it, bad); end
      consume();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sat();
    test_wrap_rows();
    test_back_to_back();
    test_table_write();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
